// File: rtl/trap_ctrl_unit.sv
// Commit-stage trap/return sequencer: prioritises WB-stage exceptions, MRET and
// external interrupts, strobes the machine-mode CSR file and redirects the PC.
module trap_ctrl_unit #(
  parameter int XLEN      = 32,
  parameter int INT_CAUSE = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_wb,
  input  logic [XLEN-1:0] pc_wb,
  input  logic [31:0]     inst_wb,
  input  logic            illegal_inst,
  input  logic            ecall,
  input  logic            l_fault,
  input  logic            s_fault,
  input  logic [XLEN-1:0] mem_addr,
  input  logic            mret,
  input  logic            ext_int,
  input  logic            csr_w,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc_i,
  output logic            is_trap,
  output logic            is_mret,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic            flush,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    RET   = 2'd2,
    REDIR = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] INT_MCAUSE = {1'b1, (XLEN-1)'(INT_CAUSE)};
  localparam logic [XLEN-1:0] INT_OFFSET = XLEN'(4 * INT_CAUSE);

  state_t          state_r;
  logic            ext_int_q_r;
  logic            int_pend_r;
  logic            trap_is_int_r;
  logic [XLEN-1:0] hold_mcause_r;
  logic [XLEN-1:0] hold_mtval_r;
  logic            is_trap_r;
  logic            is_mret_r;
  logic            flush_r;
  logic            redirect_r;
  logic [XLEN-1:0] mepc_r;
  logic [XLEN-1:0] mcause_r;
  logic [XLEN-1:0] mtval_r;
  logic [XLEN-1:0] redirect_pc_r;

  logic            take_int_s;
  logic            exc_s;
  logic            slot_s;
  logic            trap_ev_s;
  logic            ret_ev_s;
  logic [XLEN-1:0] cause_s;
  logic [XLEN-1:0] tval_s;
  logic [XLEN-1:0] tvec_base_s;
  logic            unused_s;

  assign unused_s = ^{mstatus[XLEN-1:4], mstatus[2:0]};

  // Event qualification and priority encoding of cause/tval for the WB slot
  always_comb begin
    take_int_s  = int_pend_r & mstatus[3];
    exc_s       = illegal_inst | ecall | l_fault | s_fault;
    slot_s      = (state_r == IDLE) & valid_wb;
    trap_ev_s   = slot_s & (take_int_s | exc_s);
    ret_ev_s    = slot_s & mret & ~take_int_s & ~exc_s;
    tvec_base_s = {mtvec[XLEN-1:2], 2'b00};
    cause_s     = {XLEN{1'b0}};
    tval_s      = {XLEN{1'b0}};
    if (take_int_s) begin
      cause_s = INT_MCAUSE;
    end else if (illegal_inst) begin
      cause_s = XLEN'(2);
      tval_s  = XLEN'(inst_wb);
    end else if (ecall) begin
      cause_s = XLEN'(11);
    end else if (l_fault) begin
      cause_s = XLEN'(5);
      tval_s  = mem_addr;
    end else if (s_fault) begin
      cause_s = XLEN'(7);
      tval_s  = mem_addr;
    end else begin
      cause_s = {XLEN{1'b0}};
    end
  end

  // Sequencer FSM with registered strobes and captured trap fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      ext_int_q_r   <= 1'b0;
      int_pend_r    <= 1'b0;
      trap_is_int_r <= 1'b0;
      hold_mcause_r <= {XLEN{1'b0}};
      hold_mtval_r  <= {XLEN{1'b0}};
      is_trap_r     <= 1'b0;
      is_mret_r     <= 1'b0;
      flush_r       <= 1'b0;
      redirect_r    <= 1'b0;
      mepc_r        <= {XLEN{1'b0}};
      mcause_r      <= {XLEN{1'b0}};
      mtval_r       <= {XLEN{1'b0}};
      redirect_pc_r <= {XLEN{1'b0}};
    end else begin
      ext_int_q_r <= ext_int;
      // A new edge in the same cycle as the take keeps the request pending
      int_pend_r  <= (ext_int & ~ext_int_q_r) | (int_pend_r & ~(trap_ev_s & take_int_s));
      case (state_r)
        IDLE: begin
          if (trap_ev_s) begin
            state_r       <= TRAP;
            is_trap_r     <= 1'b1;
            flush_r       <= 1'b1;
            mepc_r        <= pc_wb;
            mcause_r      <= cause_s;
            mtval_r       <= tval_s;
            trap_is_int_r <= take_int_s;
          end else if (ret_ev_s) begin
            state_r   <= RET;
            is_mret_r <= 1'b1;
            flush_r   <= 1'b1;
            mepc_r    <= mepc_i;
            mcause_r  <= hold_mcause_r;
            mtval_r   <= hold_mtval_r;
          end else begin
            state_r <= IDLE;
          end
        end
        TRAP: begin
          if (!csr_w) begin
            state_r       <= REDIR;
            is_trap_r     <= 1'b0;
            redirect_r    <= 1'b1;
            hold_mcause_r <= mcause_r;
            hold_mtval_r  <= mtval_r;
            if (trap_is_int_r && (mtvec[1:0] == 2'b01)) begin
              redirect_pc_r <= tvec_base_s + INT_OFFSET;
            end else begin
              redirect_pc_r <= tvec_base_s;
            end
          end else begin
            state_r <= TRAP;
          end
        end
        RET: begin
          if (!csr_w) begin
            state_r       <= REDIR;
            is_mret_r     <= 1'b0;
            redirect_r    <= 1'b1;
            redirect_pc_r <= mepc_i;
          end else begin
            state_r <= RET;
            mepc_r  <= mepc_i;
          end
        end
        REDIR: begin
          state_r    <= IDLE;
          redirect_r <= 1'b0;
          flush_r    <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          is_trap_r  <= 1'b0;
          is_mret_r  <= 1'b0;
          redirect_r <= 1'b0;
          flush_r    <= 1'b0;
        end
      endcase
    end
  end

  assign is_trap     = is_trap_r;
  assign is_mret     = is_mret_r;
  assign flush       = flush_r;
  assign redirect    = redirect_r;
  assign mepc        = mepc_r;
  assign mcause      = mcause_r;
  assign mtval       = mtval_r;
  assign redirect_pc = redirect_pc_r;

endmodule

// File: tb/tb_trap_ctrl_unit.sv
// Directed bench for trap_ctrl_unit: linear stimulus with hand-computed expectations.
module tb_trap_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_wb, illegal_inst, ecall, l_fault, s_fault, mret, ext_int, csr_w;
  logic [31:0] pc_wb, inst_wb, mem_addr, mstatus, mtvec, mepc_i;
  logic        is_trap, is_mret, flush, redirect;
  logic [31:0] mepc, mcause, mtval, redirect_pc;

  int checks = 0;
  int errors = 0;

  trap_ctrl_unit #(.XLEN(32), .INT_CAUSE(11)) dut (
    .clk(clk), .rst(rst), .valid_wb(valid_wb), .pc_wb(pc_wb), .inst_wb(inst_wb),
    .illegal_inst(illegal_inst), .ecall(ecall), .l_fault(l_fault), .s_fault(s_fault),
    .mem_addr(mem_addr), .mret(mret), .ext_int(ext_int), .csr_w(csr_w),
    .mstatus(mstatus), .mtvec(mtvec), .mepc_i(mepc_i), .is_trap(is_trap),
    .is_mret(is_mret), .mepc(mepc), .mcause(mcause), .mtval(mtval), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ev();
    valid_wb = 1'b0; illegal_inst = 1'b0; ecall = 1'b0; l_fault = 1'b0;
    s_fault = 1'b0; mret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr_ev(); ext_int = 1'b0; csr_w = 1'b0;
    pc_wb = 32'h0; inst_wb = 32'h0; mem_addr = 32'h0; mstatus = 32'h0;
    mtvec = 32'h200; mepc_i = 32'h0;
    #2;
    chk("rst_is_trap", is_trap, 32'd0);
    chk("rst_flush", flush, 32'd0);
    chk("rst_redirect", redirect, 32'd0);
    chk("rst_mcause", mcause, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Illegal instruction
    valid_wb = 1'b1; illegal_inst = 1'b1; pc_wb = 32'h100; inst_wb = 32'hFFFF_FFFF;
    tick(); clr_ev();
    chk("ill_is_trap", is_trap, 32'd1);
    chk("ill_flush", flush, 32'd1);
    chk("ill_mcause", mcause, 32'd2);
    chk("ill_mtval", mtval, 32'hFFFF_FFFF);
    chk("ill_mepc", mepc, 32'h100);
    chk("ill_no_redir", redirect, 32'd0);
    tick();
    chk("ill_redirect", redirect, 32'd1);
    chk("ill_redir_pc", redirect_pc, 32'h200);
    chk("ill_trap_done", is_trap, 32'd0);
    tick();
    chk("ill_idle_redir", redirect, 32'd0);
    chk("ill_idle_flush", flush, 32'd0);
    chk("ill_hold_mcause", mcause, 32'd2);

    // ECALL stalled by CSR writes for two cycles
    valid_wb = 1'b1; ecall = 1'b1; pc_wb = 32'h180;
    tick(); clr_ev(); csr_w = 1'b1;
    chk("ecall_trap_c1", is_trap, 32'd1);
    chk("ecall_mcause", mcause, 32'd11);
    chk("ecall_mtval", mtval, 32'd0);
    tick();
    chk("ecall_trap_c2", is_trap, 32'd1);
    chk("ecall_stall_c2", redirect, 32'd0);
    tick(); csr_w = 1'b0;
    chk("ecall_trap_c3", is_trap, 32'd1);
    chk("ecall_stall_c3", redirect, 32'd0);
    tick();
    chk("ecall_trap_end", is_trap, 32'd0);
    chk("ecall_redirect", redirect, 32'd1);
    chk("ecall_redir_pc", redirect_pc, 32'h200);
    tick();

    // Interrupt with MIE=1, vectored mtvec
    mstatus = 32'h8; mtvec = 32'h201; ext_int = 1'b1;
    tick(); ext_int = 1'b0; valid_wb = 1'b1; pc_wb = 32'h40;
    tick();
    chk("int_is_trap", is_trap, 32'd1);
    chk("int_mcause", mcause, 32'h8000_000B);
    chk("int_mepc", mepc, 32'h40);
    chk("int_mtval", mtval, 32'd0);
    tick();
    chk("int_redirect", redirect, 32'd1);
    chk("int_redir_pc", redirect_pc, 32'h22C);
    tick();
    tick();
    chk("int_cleared", is_trap, 32'd0);
    clr_ev();

    // Interrupt masked by MIE=0, then unmasked
    mstatus = 32'h0; mtvec = 32'h200; ext_int = 1'b1;
    tick(); ext_int = 1'b0; valid_wb = 1'b1; pc_wb = 32'h80;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mask_no_trap", is_trap, 32'd0);
    end
    mstatus = 32'h8;
    tick(); clr_ev();
    chk("unmask_trap", is_trap, 32'd1);
    chk("unmask_mcause", mcause, 32'h8000_000B);
    chk("unmask_mepc", mepc, 32'h80);
    tick();
    chk("unmask_redir_pc", redirect_pc, 32'h200);
    tick();

    // MRET
    valid_wb = 1'b1; mret = 1'b1; mepc_i = 32'h104;
    tick(); clr_ev();
    chk("mret_is_mret", is_mret, 32'd1);
    chk("mret_no_trap", is_trap, 32'd0);
    chk("mret_mepc", mepc, 32'h104);
    chk("mret_mcause_held", mcause, 32'h8000_000B);
    chk("mret_flush", flush, 32'd1);
    tick();
    chk("mret_done", is_mret, 32'd0);
    chk("mret_redirect", redirect, 32'd1);
    chk("mret_redir_pc", redirect_pc, 32'h104);
    tick();

    // Load fault together with MRET: exception wins
    valid_wb = 1'b1; mret = 1'b1; l_fault = 1'b1; mem_addr = 32'h3000; pc_wb = 32'h1C0;
    tick(); clr_ev();
    chk("lf_is_trap", is_trap, 32'd1);
    chk("lf_no_mret", is_mret, 32'd0);
    chk("lf_mcause", mcause, 32'd5);
    chk("lf_mtval", mtval, 32'h3000);
    tick(); tick();

    // Store fault
    valid_wb = 1'b1; s_fault = 1'b1; mem_addr = 32'h4004;
    tick(); clr_ev();
    chk("sf_mcause", mcause, 32'd7);
    chk("sf_mtval", mtval, 32'h4004);
    tick(); tick();

    // Reset asserted during TRAP
    valid_wb = 1'b1; illegal_inst = 1'b1; pc_wb = 32'h300;
    tick(); clr_ev();
    chk("rtrap_pre", is_trap, 32'd1);
    rst = 1'b1;
    #1;
    chk("rtrap_is_trap", is_trap, 32'd0);
    chk("rtrap_flush", flush, 32'd0);
    chk("rtrap_mepc", mepc, 32'd0);
    chk("rtrap_mcause", mcause, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rtrap_no_redir", redirect, 32'd0);
      chk("rtrap_no_flush", flush, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
